// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART word and FIFO sizing constants
package uart_pkg;
   localparam int UART_WORD_W                = 9;
   localparam int UART_RX_FIFO_DEPTH_DEFAULT = 16;
   localparam int UART_ERRCNT_W              = 8;
endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x WIDTH register array, sync write, async read
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_RX_FIFO_DEPTH_DEFAULT,
   parameter int WIDTH = UART_WORD_W
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT receive FIFO behind the UART receiver; UART_RX_FIFO_ERRCNT_EN enables the error counter
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_RX_FIFO_DEPTH_DEFAULT,
   parameter int WIDTH = UART_WORD_W
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [WIDTH-1:0]         i_rx_parallel,
   input  logic                     i_rx_valid,
   input  logic                     i_rx_error,
   input  logic                     i_pop,
   input  logic                     i_clear_flags,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overflow,
   output logic [UART_ERRCNT_W-1:0] o_err_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          r_valid_d;
   logic          push, push_ok, pop_ok, ovf_evt;

   assign o_empty = (wr_ptr == rd_ptr);
   assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign o_count = wr_ptr - rd_ptr;

   // One push per frame: only the rising edge of the held valid level counts.
   assign push    = i_rx_valid & ~r_valid_d;
   assign pop_ok  = i_pop & ~o_empty;
   assign push_ok = push & (~o_full | i_pop);
   assign ovf_evt = push & o_full & ~i_pop;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         r_valid_d  <= 1'b1;
         o_overflow <= 1'b0;
      end else begin
         r_valid_d <= i_rx_valid;
         wr_ptr    <= wr_ptr + PW'(push_ok);
         rd_ptr    <= rd_ptr + PW'(pop_ok);
         if (ovf_evt)            o_overflow <= 1'b1;
         else if (i_clear_flags) o_overflow <= 1'b0;
      end
   end

   uart_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
      .clk   (i_clk),
      .we    (push_ok),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (i_rx_parallel),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (o_data)
   );

`ifdef UART_RX_FIFO_ERRCNT_EN
   logic [UART_ERRCNT_W-1:0] err_cnt;

   // A new error in the clearing cycle wins and restarts the count at one.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         err_cnt <= '0;
      else if (i_rx_error)
         err_cnt <= i_clear_flags ? UART_ERRCNT_W'(1)
                  : (err_cnt == '1) ? err_cnt : err_cnt + UART_ERRCNT_W'(1);
      else if (i_clear_flags)
         err_cnt <= '0;
   end

   assign o_err_count = err_cnt;
`else
   logic unused_rx_error;
   assign unused_rx_error = i_rx_error;
   assign o_err_count     = '0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
   import uart_pkg::*;
   localparam int DEPTH = 16;
   localparam int WIDTH = 9;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid, rx_error, pop, clr;
   logic [WIDTH-1:0] o_data;
   logic             o_empty, o_full, o_overflow;
   logic [4:0]       o_count;
   logic [7:0]       o_err_count;

   int checks = 0;
   int errors = 0;

   int q[$];
   bit m_prev;
   bit m_ovf;
   int m_err;

   typedef struct {
      bit valid;
      int data;
      bit pop;
      int cyc;
      int exp_count;
      int exp_data;
   } vec_t;
   vec_t tbl [15];

   uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_rx_parallel(rx_data), .i_rx_valid(rx_valid),
      .i_rx_error(rx_error), .i_pop(pop), .i_clear_flags(clr),
      .o_data(o_data), .o_empty(o_empty), .o_full(o_full), .o_count(o_count),
      .o_overflow(o_overflow), .o_err_count(o_err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_prev = 1'b1;
      m_ovf  = 1'b0;
      m_err  = 0;
   endtask

   // Behavioural view: a bounded queue of words, one capture per valid rise.
   task automatic model_edge();
      bit push, was_full;
      push     = rx_valid && !m_prev;
      was_full = (q.size() == DEPTH);
      if (pop && q.size() > 0) void'(q.pop_front());
      if (push && (!was_full || pop)) q.push_back(int'(rx_data));
      if (push && was_full && !pop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
`ifdef UART_RX_FIFO_ERRCNT_EN
      if (rx_error) m_err = clr ? 1 : (m_err < 255 ? m_err + 1 : 255);
      else if (clr) m_err = 0;
`endif
      m_prev = rx_valid;
   endtask

   task automatic cmp_all();
      chk("count", int'(o_count), q.size());
      chk("empty", int'(o_empty), int'(q.size() == 0));
      chk("full", int'(o_full), int'(q.size() == DEPTH));
      chk("overflow", int'(o_overflow), int'(m_ovf));
      chk("err_count", int'(o_err_count), m_err);
      if (q.size() > 0) chk("data", int'(o_data), q[0]);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cmp_all();
   endtask

   task automatic push_word(input int w);
      rx_valid = 1'b1; rx_data = WIDTH'(w); step();
      rx_valid = 1'b0; step();
   endtask

   initial begin
      tbl = '{
         '{1, 'h1A5, 0, 5,  0, -1},
         '{0, 'h000, 0, 2,  0, -1},
         '{1, 'h055, 0, 20, 1, 'h055},
         '{0, 'h000, 0, 3,  1, 'h055},
         '{1, 'h0AA, 0, 20, 2, 'h055},
         '{0, 'h000, 0, 3,  2, 'h055},
         '{1, 'h1FF, 0, 20, 3, 'h055},
         '{0, 'h000, 0, 2,  3, 'h055},
         '{0, 'h000, 1, 1,  2, 'h0AA},
         '{0, 'h000, 1, 1,  1, 'h1FF},
         '{0, 'h000, 1, 1,  0, -1},
         '{0, 'h000, 1, 1,  0, -1},
         '{1, 'h077, 1, 1,  1, 'h077},
         '{1, 'h077, 0, 3,  1, 'h077},
         '{0, 'h000, 1, 1,  0, -1}
      };

      // Valid already high across reset release must not be captured.
      rst = 1'b1; rx_valid = 1'b1; rx_data = 9'h1A5; rx_error = 1'b0; pop = 1'b0; clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_empty", int'(o_empty), 1);
      chk("rst_full", int'(o_full), 0);
      chk("rst_count", int'(o_count), 0);
      chk("rst_overflow", int'(o_overflow), 0);
      chk("rst_err_count", int'(o_err_count), 0);

      for (int r = 0; r < 15; r++) begin
         rx_valid = tbl[r].valid; rx_data = WIDTH'(tbl[r].data); pop = tbl[r].pop;
         for (int c = 0; c < tbl[r].cyc; c++) step();
         chk($sformatf("tbl%0d_count", r), int'(o_count), tbl[r].exp_count);
         if (tbl[r].exp_data >= 0) chk($sformatf("tbl%0d_data", r), int'(o_data), tbl[r].exp_data);
      end
      rx_valid = 1'b0; pop = 1'b0; step();

      for (int i = 0; i < DEPTH; i++) push_word(i);
      chk("fill_full", int'(o_full), 1);
      push_word('h100);
      chk("ovf_set", int'(o_overflow), 1);
      chk("ovf_count", int'(o_count), DEPTH);
      clr = 1'b1; step(); clr = 1'b0;
      chk("ovf_clear", int'(o_overflow), 0);
      chk("head_before_coincident", int'(o_data), 0);
      rx_valid = 1'b1; rx_data = 9'h033; pop = 1'b1; step();
      rx_valid = 1'b0; pop = 1'b0; step();
      chk("coincident_count", int'(o_count), DEPTH);
      chk("coincident_ovf", int'(o_overflow), 0);
      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("drain%0d", i), int'(o_data), (i == DEPTH - 1) ? 'h033 : i + 1);
         pop = 1'b1; step();
      end
      pop = 1'b0; step();
      chk("drain_empty", int'(o_empty), 1);

      // Asynchronous reset clears occupancy without waiting for an edge.
      push_word('h0C3); push_word('h13C);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_rst_empty", int'(o_empty), 1);
      chk("async_rst_count", int'(o_count), 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      step();

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(3) == 0) begin
            if (!rx_valid) rx_data = WIDTH'($urandom);
            rx_valid = !rx_valid;
         end
         pop      = (n < 1500) ? ($urandom_range(5) == 0) : ($urandom_range(1) == 0);
         clr      = ($urandom_range(49) == 0);
         rx_error = ($urandom_range(7) == 0);
         step();
      end
      rx_valid = 1'b0; pop = 1'b0; clr = 1'b1; rx_error = 1'b0; step(); clr = 1'b0;

      for (int i = 0; i < 300; i++) begin
         rx_error = 1'b1; step();
         rx_error = 1'b0; step();
      end
`ifdef UART_RX_FIFO_ERRCNT_EN
      chk("err_saturate", int'(o_err_count), 255);
`else
      chk("err_disabled", int'(o_err_count), 0);
`endif
      rx_error = 1'b1; clr = 1'b1; step();
      rx_error = 1'b0; clr = 1'b0;
`ifdef UART_RX_FIFO_ERRCNT_EN
      chk("err_clear_race", int'(o_err_count), 1);
`else
      chk("err_clear_race_disabled", int'(o_err_count), 0);
`endif
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
